// File: rtl/inst_fetch_queue.sv
// Fetch queue: 1-cycle ROM reads into a DEPTH ring, valid/ready to IF/ID, fetch-to-valid 2 cycles; issue stalls when ring+in-flight fill DEPTH.
// IFQ_BYPASS_EN: a kept response landing on an empty ring drives the outputs in its arrival cycle (1-cycle latency).
module inst_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              inst_ready_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q, target_q, infl_pc_q;
  logic [DATA_W-1:0] mem_dat [DEPTH];
  logic [ADDR_W-1:0] mem_pc  [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;
  logic              inflight_q, keep_q, redirect_pend_q;

  logic q_empty, resp_kept, bypass, pop, pop_q, push, issue, wr_en;

  assign q_empty   = (count_q == '0);
  assign resp_kept = inflight_q && keep_q;
`ifdef IFQ_BYPASS_EN
  assign bypass = q_empty && resp_kept;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid_o = !q_empty || bypass;

  always_comb begin
    inst_o = '0;
    pc_o   = '0;
    if (!q_empty) begin
      inst_o = mem_dat[head_q];
      pc_o   = mem_pc[head_q];
    end else if (bypass) begin
      inst_o = rom_data_i;
      pc_o   = infl_pc_q;
    end
  end

  assign pop   = inst_valid_o && inst_ready_i;
  assign pop_q = pop && !q_empty;
  // A bypassed response consumed in its arrival cycle never occupies a slot.
  assign push  = resp_kept && !(bypass && pop);

  assign rom_ce_o   = !rst && (({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < DEPTH_C);
  assign rom_addr_o = pc_q;
  assign issue      = rom_ce_o && !branch_flag_i;

  // On a redirect only an unpopped response landing on an empty ring survives as the delay slot.
  assign wr_en = push && (!branch_flag_i || (!pop && q_empty));

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_dat[tail_q] <= rom_data_i;
      mem_pc[tail_q]  <= infl_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      target_q        <= '0;
      infl_pc_q       <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      inflight_q      <= 1'b0;
      keep_q          <= 1'b0;
      redirect_pend_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        infl_pc_q       <= pc_q;
        keep_q          <= 1'b1;
        pc_q            <= redirect_pend_q ? target_q : pc_q + ADDR_W'(4);
        redirect_pend_q <= 1'b0;
      end
      if (branch_flag_i) begin
        keep_q <= 1'b0;
        if (pop) begin
          head_q  <= '0;
          tail_q  <= '0;
          count_q <= '0;
          pc_q    <= branch_target_address_i;
        end else if (!q_empty) begin
          tail_q  <= head_q + 1'b1;
          count_q <= CW'(1);
          pc_q    <= branch_target_address_i;
        end else if (resp_kept) begin
          tail_q  <= tail_q + 1'b1;
          count_q <= CW'(1);
          pc_q    <= branch_target_address_i;
        end else begin
          // Delay slot not yet fetched: fetch old pc_q first, then jump.
          redirect_pend_q <= 1'b1;
          target_q        <= branch_target_address_i;
        end
      end else begin
        if (push)  tail_q <= tail_q + 1'b1;
        if (pop_q) head_q <= head_q + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop_q);
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random ready/branch/reset traffic against a queue-based model.
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data = 32'h0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_ready_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_address_i = 32'h0;

  inst_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o), .inst_ready_i(inst_ready_i),
    .branch_flag_i(branch_flag_i), .branch_target_address_i(branch_target_address_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) if (rom_ce_o) rom_data <= rom_word(rom_addr_o);

  typedef struct { logic [31:0] pc; logic [31:0] dat; } ent_t;

  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.pc  = pc;
    e.dat = rom_word(pc);
    return e;
  endfunction

  ent_t        mq[$];
  logic [31:0] minfl[$];
  logic [31:0] mpc, mtgt;
  bit          mpend, mknown;
  logic [31:0] popped[$];
  int          n_cmp, n_err, n_issue;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit rdy, input bit br, input logic [31:0] tgt);
    bit   resp, byp, e_valid, e_ce, e_pop, case4;
    ent_t head;
    @(negedge clk);
    rst = r; inst_ready_i = rdy; branch_flag_i = br; branch_target_address_i = tgt;
    #1;
    resp    = (minfl.size() != 0);
    byp     = BYP && (mq.size() == 0) && resp;
    e_valid = (mq.size() != 0) || byp;
    head    = mk(32'h0);
    if (mq.size() != 0) head = mq[0];
    else if (byp) head = mk(minfl[0]);
    e_ce = !r && ((mq.size() + minfl.size()) < DEPTH);
    if (mknown) begin
      check("rom_ce", 32'(rom_ce_o), 32'(e_ce));
      check("rom_addr", rom_addr_o, mpc);
      check("inst_valid", 32'(inst_valid_o), 32'(e_valid));
      if (e_valid) begin
        check("pc", pc_o, head.pc);
        check("inst", inst_o, head.dat);
      end else if (r) begin
        check("rst_pc", pc_o, 32'h0);
        check("rst_inst", inst_o, 32'h0);
      end
    end
    if (inst_valid_o && rdy && !r) popped.push_back(pc_o);
    if (rom_ce_o && !br) n_issue++;
    if (r) begin
      mq.delete(); minfl.delete();
      mpend = 0; mpc = RESET_PC; mknown = 1;
    end else if (mknown) begin
      e_pop = e_valid && rdy;
      if (br) begin
        case4 = !e_pop && (mq.size() == 0) && !resp;
        if (e_pop) mq.delete();
        else if (mq.size() != 0) while (mq.size() > 1) void'(mq.pop_back());
        else if (resp) mq.push_back(mk(minfl[0]));
        if (case4) begin mpend = 1; mtgt = tgt; end
        else mpc = tgt;
        minfl.delete();
      end else begin
        if (e_pop && !byp) void'(mq.pop_front());
        if (resp && !(byp && e_pop)) mq.push_back(mk(minfl[0]));
        minfl.delete();
        if (e_ce) begin
          minfl.push_back(mpc);
          mpc   = mpend ? mtgt : mpc + 32'd4;
          mpend = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    popped.delete();
  endtask

  task automatic run_until_pops(input int n, input int limit);
    int k = 0;
    while (popped.size() < n && k < limit) begin
      step(0, 1, 0, 32'h0);
      k++;
    end
    check("wait_pops", 32'(popped.size() >= n), 32'd1);
  endtask

  initial begin
    int first_pop, k;
    n_cmp = 0; n_err = 0; n_issue = 0; mknown = 0; mpend = 0;

    // Streaming from reset
    do_reset();
    first_pop = -1;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 32'h0);
      if (first_pop < 0 && popped.size() > 0) first_pop = i;
    end
    check("first_pop_cycle", 32'(first_pop), BYP ? 32'd1 : 32'd2);
    for (int i = 0; i < 4; i++) check("stream_pc", popped[i], 32'(i * 4));

    // Stall fills exactly DEPTH, then drains in order
    do_reset();
    n_issue = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 32'h0);
    check("stall_issues", 32'(n_issue), 32'(DEPTH));
    check("stall_ce", 32'(rom_ce_o), 32'd0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 32'h0);
    for (int i = 0; i < 5; i++) check("drain_pc", popped[i], 32'(i * 4));

    // Branch without pop: head kept as delay slot
    do_reset();
    run_until_pops(2, 20);
    step(0, 0, 1, 32'h100);
    run_until_pops(5, 20);
    check("br_slot", popped[2], 32'h8);
    check("br_tgt0", popped[3], 32'h100);
    check("br_tgt1", popped[4], 32'h104);

    // Branch with pop, then branch while empty with nothing in flight
    do_reset();
    run_until_pops(2, 20);
    step(0, 1, 1, 32'h40);
    check("popbr_slot", popped[2], 32'h8);
    step(0, 1, 1, 32'h200);
    check("pend_addr_br", rom_addr_o, 32'h40);
    step(0, 1, 0, 32'h0);
    check("pend_addr_slot", rom_addr_o, 32'h40);
    step(0, 1, 0, 32'h0);
    check("pend_addr_tgt", rom_addr_o, 32'h200);
    run_until_pops(5, 20);
    check("pend_pop_slot", popped[3], 32'h40);
    check("pend_pop_tgt", popped[4], 32'h200);

    // Reset with 3 queued and one in flight
    do_reset();
    k = 0;
    while (!(mq.size() == 3 && minfl.size() == 1) && k < 20) begin
      step(0, 0, 0, 32'h0);
      k++;
    end
    check("wait_fill3", 32'(mq.size() == 3 && minfl.size() == 1), 32'd1);
    step(1, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    check("rst_flush_valid", 32'(inst_valid_o), 32'd0);
    check("rst_restart_addr", rom_addr_o, RESET_PC);
    check("rst_restart_ce", 32'(rom_ce_o), 32'd1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 8, tgt);
    end
    check("random_progress", 32'(popped.size() > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
